hcsr04_ranger: RTL and testbench

//  Drives one HC-SR04 sensor: issues the trigger pulse, times the echo pulse and converts
//  the echo width to a 12-bit distance in cm.
//  One instance per sensor. distance feeds the limit/LED-matrix logic directly.
//  12'hFFF means "no echo / beyond range"; downstream compares treat it as far.

---
 rtl/hcsr04_pkg.sv | 24 ++
 rtl/hcsr04_ranger_echo_sync.sv | 30 +++
 rtl/hcsr04_ranger.sv | 170 +++++++++++++++++
 tb/tb_hcsr04_ranger.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// Shared types and constants for the HC-SR04 ranger and the limit/LED logic
// that consumes its distance output.
package hcsr04_pkg;

  localparam int DIST_W = 12;
  localparam logic [DIST_W-1:0] DIST_FAR = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  function automatic logic [DIST_W-1:0] median3(input logic [DIST_W-1:0] a,
                                                input logic [DIST_W-1:0] b,
                                                input logic [DIST_W-1:0] c);
    if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
    else if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
    else return c;
  endfunction

endpackage

// File: rtl/hcsr04_ranger_echo_sync.sv
// Two-flop synchronizer for the raw sensor echo, with single-cycle rise/fall
// pulses derived from the synchronized level.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic echo_s,
  output logic echo_rise,
  output logic echo_fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      echo_s <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= echo;
      echo_s <= meta;
      prev   <= echo_s;
    end
  end

  assign echo_rise = echo_s & ~prev;
  assign echo_fall = ~echo_s & prev;

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 driver: periodic trigger, echo timing and cm conversion.
// Define HCSR04_MEDIAN_EN to publish the median of the last 3 valid samples.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | trig low; start on enable, echo low and period wrap/first run
// TRIG      | trig high for TRIG_CYCLES cycles
// WAIT_RISE | waiting for echo to rise, bounded by RISE_TIMEOUT
// MEASURE   | counting echo-high cycles into whole cm
// HOLDOFF   | result published; waiting out the rest of the period
module hcsr04_ranger
  import hcsr04_pkg::*;
#(
  parameter int TRIG_CYCLES   = 500,
  parameter int CYCLES_PER_CM = 2900,
  parameter int MAX_CM        = 400,
  parameter int RISE_TIMEOUT  = 1_500_000,
  parameter int PERIOD_CYCLES = 3_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              valid,
  output logic              no_echo
);

  localparam int TMR_MAX = (RISE_TIMEOUT > TRIG_CYCLES) ? RISE_TIMEOUT : TRIG_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int PER_W   = $clog2(PERIOD_CYCLES);
  localparam int CYC_W   = $clog2(CYCLES_PER_CM);

  localparam logic [TMR_W-1:0]  TRIG_LOAD = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0]  RISE_LOAD = TMR_W'(RISE_TIMEOUT - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [PER_W-1:0]  PER_EXIT  = PER_W'(PERIOD_CYCLES - 2);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_LAST   = DIST_W'(MAX_CM);

  state_t            state;
  logic [TMR_W-1:0]  tmr;
  logic [PER_W-1:0]  period_cnt;
  logic              period_run;
  logic              first_start;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [DIST_W-1:0] cm_cnt;
  logic [DIST_W-1:0] pub_dist;

  logic echo_s, echo_rise, echo_fall;
  logic period_wrap, cyc_tc, pub_timeout, pub_meas, pub_over, pub_en;

  echo_sync u_echo_sync (
    .clk       (clk),
    .rst       (rst),
    .echo      (echo),
    .echo_s    (echo_s),
    .echo_rise (echo_rise),
    .echo_fall (echo_fall)
  );

  always_comb begin
    period_wrap = period_run && (period_cnt == PER_LAST);
    cyc_tc      = (cyc_cnt == CYC_LAST);
    pub_timeout = (state == WAIT_RISE) && !echo_rise && (tmr == '0);
    pub_meas    = (state == MEASURE) && echo_fall;
    pub_over    = (state == MEASURE) && !echo_fall && cyc_tc && (cm_cnt == CM_LAST);
    pub_en      = pub_timeout || pub_meas || pub_over;
  end

`ifdef HCSR04_MEDIAN_EN
  // hist0 is the newest stored sample; the current sample is the third voter.
  logic [DIST_W-1:0] hist0, hist1;
  logic              hist_ok;
  assign pub_dist = hist_ok ? median3(cm_cnt, hist0, hist1) : cm_cnt;
`else
  assign pub_dist = cm_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      trig        <= 1'b0;
      distance    <= DIST_FAR;
      valid       <= 1'b0;
      no_echo     <= 1'b0;
      tmr         <= '0;
      period_cnt  <= '0;
      period_run  <= 1'b0;
      first_start <= 1'b1;
      cyc_cnt     <= '0;
      cm_cnt      <= '0;
`ifdef HCSR04_MEDIAN_EN
      hist0       <= '0;
      hist1       <= '0;
      hist_ok     <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      if (period_run) period_cnt <= period_wrap ? '0 : period_cnt + PER_W'(1);

      if (pub_en) begin
        valid <= 1'b1;
        if (pub_meas) begin
          distance <= pub_dist;
          no_echo  <= 1'b0;
`ifdef HCSR04_MEDIAN_EN
          hist0    <= cm_cnt;
          hist1    <= hist_ok ? hist0 : cm_cnt;
          hist_ok  <= 1'b1;
`endif
        end else begin
          distance <= DIST_FAR;
          no_echo  <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          trig <= 1'b0;
          if (enable && !echo_s && (first_start || period_wrap)) begin
            state       <= TRIG;
            trig        <= 1'b1;
            tmr         <= TRIG_LOAD;
            period_cnt  <= '0;
            period_run  <= 1'b1;
            first_start <= 1'b0;
          end
        end
        TRIG: begin
          if (tmr == '0) begin
            state <= WAIT_RISE;
            trig  <= 1'b0;
            tmr   <= RISE_LOAD;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            state   <= MEASURE;
            cyc_cnt <= '0;
            cm_cnt  <= '0;
          end else if (pub_timeout) begin
            state <= HOLDOFF;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        MEASURE: begin
          if (pub_meas || pub_over) begin
            state <= HOLDOFF;
          end else if (cyc_tc) begin
            cyc_cnt <= '0;
            if (cm_cnt != '1) cm_cnt <= cm_cnt + DIST_W'(1);
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        HOLDOFF: begin
          // Leave one cycle early so IDLE sees the wrap and restarts exactly on period.
          if (period_cnt >= PER_EXIT) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger with shortened timing parameters.
module tb_hcsr04_ranger;

`ifdef HCSR04_MEDIAN_EN
  localparam bit MED = 1'b1;
`else
  localparam bit MED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, echo;
  logic        trig, valid, no_echo;
  logic [11:0] distance;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int n_rise = 0, n_fall = 0, last_rise = 0, last_fall = 0;
  logic trig_q = 1'b0;
  int          vq_cyc[$];
  logic [11:0] vq_dist[$];
  logic        vq_no[$];

  hcsr04_ranger #(
    .TRIG_CYCLES   (5),
    .CYCLES_PER_CM (10),
    .MAX_CM        (20),
    .RISE_TIMEOUT  (100),
    .PERIOD_CYCLES (400)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .echo     (echo),
    .trig     (trig),
    .distance (distance),
    .valid    (valid),
    .no_echo  (no_echo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trig === 1'b1 && trig_q !== 1'b1) begin last_rise = cyc; n_rise++; end
    if (trig === 1'b0 && trig_q === 1'b1) begin last_fall = cyc; n_fall++; end
    trig_q = trig;
    if (valid === 1'b1) begin
      vq_cyc.push_back(cyc);
      vq_dist.push_back(distance);
      vq_no.push_back(no_echo);
    end
  end

  typedef struct {
    bit rst_before;
    int delay;
    int len;
    int exp_raw;
    int exp_med;
    bit exp_no;
    int exp_lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    vq_cyc.delete();
    vq_dist.delete();
    vq_no.delete();
  endtask

  task automatic wait_fall(output bit ok);
    int nf;
    nf = n_fall;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (n_fall != nf) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rise(input int budget, output bit ok);
    int nr;
    nr = n_rise;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (n_rise != nr) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (vq_cyc.size() > 0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    echo = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    clear_q();
  endtask

  initial begin
    bit ok;
    int f, r, prev_r, nr0, rb, target, exp_d;
    vec_t v;

    tbl[0] = '{0, 20,  75, 12'h7,   12'h7,   1'b0,  98};
    tbl[1] = '{0,  0,   0, 12'hFFF, 12'hFFF, 1'b1, 100};
    tbl[2] = '{0, 20, 250, 12'hFFF, 12'hFFF, 1'b1, 233};
    tbl[3] = '{0, 10, 201, 20,      7,       1'b0, 214};
    tbl[4] = '{1, 20,  55, 5,       5,       1'b0,  78};
    tbl[5] = '{0, 20, 155, 15,      5,       1'b0, 178};
    tbl[6] = '{0,  0,   0, 12'hFFF, 12'hFFF, 1'b1, 100};
    tbl[7] = '{0, 20,  95, 9,       9,       1'b0, 118};

    rst = 1'b1; enable = 1'b1; echo = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset_trig", trig, 0);
      chk("reset_distance", distance, 12'hFFF);
      chk("reset_valid", valid, 0);
      chk("reset_no_echo", no_echo, 0);
    end
    #1;
    rst = 1'b0;
    clear_q();
    prev_r = 0;

    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      if (v.rst_before) do_reset();
      wait_fall(ok);
      chk("trig_fall_seen", ok, 1);
      if (!ok) continue;
      f = last_fall;
      r = last_rise;
      chk("trig_width", f - r, 5);
      if (i > 0 && !v.rst_before) chk("trig_period", r - prev_r, 400);
      prev_r = r;
      chk("stray_valid", vq_cyc.size(), 0);
      clear_q();
      if (v.len > 0) begin
        repeat (v.delay) tick();
        echo = 1'b1;
        repeat (v.len) tick();
        echo = 1'b0;
      end
      wait_valid(ok);
      chk("valid_seen", ok, 1);
      if (ok) begin
        exp_d = MED ? v.exp_med : v.exp_raw;
        chk("valid_latency", vq_cyc[0] - f, v.exp_lat);
        chk("distance", vq_dist[0], exp_d);
        chk("no_echo", vq_no[0], v.exp_no);
        repeat (4) tick();
        chk("valid_once", vq_cyc.size(), 1);
      end
      clear_q();
    end

    // Echo stuck high across a wrap: that period is skipped.
    echo = 1'b1;
    nr0 = n_rise;
    target = prev_r + 450;
    for (int k = 0; k < 2000 && cyc < target; k++) tick();
    chk("stuck_no_trig", n_rise - nr0, 0);
    echo = 1'b0;
    wait_rise(500, ok);
    chk("stuck_rise_seen", ok, 1);
    chk("stuck_next_rise", last_rise - prev_r, 800);
    wait_valid(ok);
    chk("stuck_timeout_valid", ok, 1);
    if (ok) chk("stuck_timeout_no_echo", vq_no[0], 1);
    clear_q();

    // Enable dropped mid-measurement: result still published, then silence.
    wait_fall(ok);
    chk("en_trig_fall_seen", ok, 1);
    rb = last_rise;
    repeat (20) tick();
    echo = 1'b1;
    repeat (20) tick();
    enable = 1'b0;
    repeat (35) tick();
    echo = 1'b0;
    wait_valid(ok);
    chk("en_drop_valid", ok, 1);
    if (ok) begin
      chk("en_drop_distance", vq_dist[0], MED ? 9 : 5);
      chk("en_drop_no_echo", vq_no[0], 0);
    end
    clear_q();
    nr0 = n_rise;
    repeat (1000) tick();
    chk("en_low_no_trig", n_rise - nr0, 0);
    enable = 1'b1;
    wait_rise(500, ok);
    chk("reenable_rise_seen", ok, 1);
    chk("reenable_phase", (last_rise - rb) % 400, 0);

    // Reset while trig is high: trig drops next cycle, nothing published.
    rst = 1'b1;
    enable = 1'b0;
    tick();
    chk("rst_trig_low", trig, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (200) tick();
    chk("rst_no_publish", vq_cyc.size(), 0);
    chk("rst_distance", distance, 12'hFFF);
    chk("rst_no_echo", no_echo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
